// File: rtl/ws_array_seq_if.sv
// ws_array_seq_if
// Bundles the job-control, weight-load, row-stream and array-facing signals of
// the weight-stationary array sequencer into one interface.
//
// Parameters
//   K      array reduction height (operand lanes per row)
//   N      array width (weight columns / result columns)
//   WIDTH  operand element width
//   M_MAX  maximum rows per job; CW = $clog2(M_MAX+1)
//
// Signal summary (direction seen from the sequencer, modport slave)
//   in : start, load_w, m_rows[CW], w_valid, w_col[WIDTH*K], a_valid, a_row[WIDTH*K]
//   out: w_ready, a_ready, weight_wen, weight_din[WIDTH*K], operand_a[WIDTH*K],
//        data_valid, col_valid[N], busy, done
//   out (only with WS_ARRAY_SEQ_PERF_EN): perf_busy_cyc[32], perf_bubble_cyc[32]
//
// The master modport is the mirror image, for whatever issues jobs and data.
interface ws_array_seq_if #(
    parameter int K     = 32,
    parameter int N     = 32,
    parameter int WIDTH = 8,
    parameter int M_MAX = 1024
);
    localparam int CW = $clog2(M_MAX + 1);

    logic                 start;
    logic                 load_w;
    logic [CW-1:0]        m_rows;
    logic                 w_valid;
    logic                 w_ready;
    logic [WIDTH*K-1:0]   w_col;
    logic                 a_valid;
    logic                 a_ready;
    logic [WIDTH*K-1:0]   a_row;
    logic                 weight_wen;
    logic [WIDTH*K-1:0]   weight_din;
    logic [WIDTH*K-1:0]   operand_a;
    logic                 data_valid;
    logic [N-1:0]         col_valid;
    logic                 busy;
    logic                 done;
`ifdef WS_ARRAY_SEQ_PERF_EN
    logic [31:0]          perf_busy_cyc;
    logic [31:0]          perf_bubble_cyc;
`endif

    modport slave (
        input  start, load_w, m_rows, w_valid, w_col, a_valid, a_row,
        output w_ready, a_ready, weight_wen, weight_din, operand_a,
               data_valid, col_valid, busy, done
`ifdef WS_ARRAY_SEQ_PERF_EN
        , output perf_busy_cyc, perf_bubble_cyc
`endif
    );

    modport master (
        output start, load_w, m_rows, w_valid, w_col, a_valid, a_row,
        input  w_ready, a_ready, weight_wen, weight_din, operand_a,
               data_valid, col_valid, busy, done
`ifdef WS_ARRAY_SEQ_PERF_EN
        , input perf_busy_cyc, perf_bubble_cyc
`endif
    );
endinterface

// File: rtl/ws_array_seq.sv
// ws_array_seq
// Sequencer for a K x N weight-stationary systolic array. A job optionally
// reloads N weight columns (first accepted column is array column N-1, last is
// column 0), then streams m_rows A rows into the array with a per-lane skew
// (lane k delayed k extra cycles), then flushes until every column has reported
// its last result, and finally pulses done.
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset; clears all state and outputs
//   bus  ws_array_seq_if.slave (job control, weight/row handshakes, array side)
//
// Optional feature: define WS_ARRAY_SEQ_PERF_EN to add saturating 32-bit
// counters perf_busy_cyc (cycles with busy=1) and perf_bubble_cyc (STREAM
// cycles with a_valid=0). They only clear on rst and accumulate across jobs.
module ws_array_seq #(
    parameter int K     = 32,
    parameter int N     = 32,
    parameter int WIDTH = 8,
    parameter int M_MAX = 1024
) (
    input  logic           clk,
    input  logic           rst,
    ws_array_seq_if.slave  bus
);
    localparam int CW = $clog2(M_MAX + 1);
    localparam int WW = $clog2(N + 1);
    localparam int FW = $clog2(K + N + 2);
    localparam int TW = K + N + 1;

    localparam logic [CW-1:0] M_MAX_C = CW'(M_MAX);
    localparam logic [WW-1:0] W_LAST  = WW'(N - 1);
    localparam logic [FW-1:0] F_LAST  = FW'(K + N + 1);
    localparam logic [FW-1:0] DV_LAST = FW'(K - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, FLUSH, DONE} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        m_rows_q, m_rows_d;
    logic [CW-1:0]        row_cnt_q, row_cnt_d;
    logic [WW-1:0]        w_cnt_q, w_cnt_d;
    logic [FW-1:0]        flush_cnt_q, flush_cnt_d;
    logic                 weight_wen_q, weight_wen_d;
    logic [WIDTH*K-1:0]   weight_din_q, weight_din_d;
    logic                 data_valid_q, data_valid_d;
    logic                 done_q, done_d;
    logic [TW-1:0]        tag_q, tag_d;

    logic                 w_acc;
    logic                 a_acc;
    logic [CW-1:0]        m_clamp;
    logic [WIDTH*K-1:0]   row_in;
    logic [WIDTH*K-1:0]   operand_a_w;

    assign w_acc   = bus.w_valid && (state_q == LOAD_W);
    assign a_acc   = bus.a_valid && (state_q == STREAM);
    assign m_clamp = (bus.m_rows > M_MAX_C) ? M_MAX_C : bus.m_rows;
    // Cycles in STREAM without a valid row push an all-zero bubble row.
    assign row_in  = a_acc ? bus.a_row : '0;

    assign bus.w_ready    = (state_q == LOAD_W);
    assign bus.a_ready    = (state_q == STREAM);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.weight_wen = weight_wen_q;
    assign bus.weight_din = weight_din_q;
    assign bus.data_valid = data_valid_q;
    assign bus.operand_a  = operand_a_w;
    // Tag bit i is the row pushed i cycles ago; column j reports K+1+j cycles
    // after its row entered the skew.
    assign bus.col_valid  = tag_q[TW-1 -: N];

    // Next-state logic; counters are cleared when a job is accepted, and
    // start is only looked at in IDLE so requests while busy are dropped.
    always_comb begin
        state_d     = state_q;
        m_rows_d    = m_rows_q;
        row_cnt_d   = row_cnt_q;
        w_cnt_d     = w_cnt_q;
        flush_cnt_d = '0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    m_rows_d  = m_clamp;
                    row_cnt_d = '0;
                    w_cnt_d   = '0;
                    if (bus.load_w)          state_d = LOAD_W;
                    else if (m_clamp != '0)  state_d = STREAM;
                    else                     state_d = DONE;
                end
            end
            LOAD_W: begin
                if (w_acc) begin
                    w_cnt_d = w_cnt_q + WW'(1);
                    if (w_cnt_q == W_LAST)
                        state_d = (m_rows_q != '0) ? STREAM : DONE;
                end
            end
            STREAM: begin
                if (a_acc && (row_cnt_q != m_rows_q)) begin
                    row_cnt_d = row_cnt_q + CW'(1);
                    if (row_cnt_q + CW'(1) == m_rows_q)
                        state_d = FLUSH;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q + FW'(1);
                if (flush_cnt_q == F_LAST) begin
                    flush_cnt_d = '0;
                    state_d     = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Registered outputs. data_valid stays up in FLUSH until the last row has
    // reached lane K-1; done is registered off the DONE state.
    always_comb begin
        weight_wen_d = w_acc;
        weight_din_d = w_acc ? bus.w_col : '0;
        data_valid_d = (state_q == STREAM) ||
                       ((state_q == FLUSH) && (flush_cnt_q < DV_LAST));
        done_d       = (state_q == DONE);
        tag_d        = {tag_q[TW-2:0], a_acc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            m_rows_q     <= '0;
            row_cnt_q    <= '0;
            w_cnt_q      <= '0;
            flush_cnt_q  <= '0;
            weight_wen_q <= 1'b0;
            weight_din_q <= '0;
            data_valid_q <= 1'b0;
            done_q       <= 1'b0;
            tag_q        <= '0;
        end else begin
            state_q      <= state_d;
            m_rows_q     <= m_rows_d;
            row_cnt_q    <= row_cnt_d;
            w_cnt_q      <= w_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            weight_wen_q <= weight_wen_d;
            weight_din_q <= weight_din_d;
            data_valid_q <= data_valid_d;
            done_q       <= done_d;
            tag_q        <= tag_d;
        end
    end

    // Skew: lane k is a (k+1)-deep shift chain, so a row pushed at edge t
    // shows lane k on operand_a after edge t+k.
    for (genvar k = 0; k < K; k++) begin : g_lane
        logic [WIDTH-1:0] chain_q [k+1];
        logic [WIDTH-1:0] chain_d [k+1];

        always_comb begin
            chain_d[0] = row_in[k*WIDTH +: WIDTH];
            for (int i = 1; i <= k; i++)
                chain_d[i] = chain_q[i-1];
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i <= k; i++)
                    chain_q[i] <= '0;
            end else begin
                for (int i = 0; i <= k; i++)
                    chain_q[i] <= chain_d[i];
            end
        end

        assign operand_a_w[k*WIDTH +: WIDTH] = chain_q[k];
    end

`ifdef WS_ARRAY_SEQ_PERF_EN
    logic [31:0] perf_busy_q, perf_busy_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;

    // Saturating activity counters, cleared only by rst.
    always_comb begin
        perf_busy_d   = perf_busy_q;
        perf_bubble_d = perf_bubble_q;
        if ((state_q != IDLE) && (perf_busy_q != '1))
            perf_busy_d = perf_busy_q + 32'd1;
        if ((state_q == STREAM) && !bus.a_valid && (perf_bubble_q != '1))
            perf_bubble_d = perf_bubble_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_busy_q   <= '0;
            perf_bubble_q <= '0;
        end else begin
            perf_busy_q   <= perf_busy_d;
            perf_bubble_q <= perf_bubble_d;
        end
    end

    assign bus.perf_busy_cyc   = perf_busy_q;
    assign bus.perf_bubble_cyc = perf_bubble_q;
`endif
endmodule

// File: doc/ws_array_seq.md
WS_ARRAY_SEQ -- requirements
Module: ws_array_seq

Interface
REQ-001 SHALL have parameter K, default 32: array reduction height (A_H); operand lanes per row.
REQ-002 SHALL have parameter N, default 32: array width (B_W); weight columns and result columns.
REQ-003 SHALL have parameter WIDTH, default 8: operand element width.
REQ-004 SHALL have parameter M_MAX, default 1024: maximum rows per job; CW = $clog2(M_MAX+1).
REQ-005 SHALL have one clock and a synchronous, active-high reset, with ports:
  clk        in   1          clock, all logic on rising edge
  rst        in   1          synchronous active-high reset
  start      in   1          job request pulse, sampled only in IDLE
  load_w     in   1          with start: 1 = reload weights before streaming
  m_rows     in   CW         rows in job, sampled with start
  w_valid    in   1          weight column valid
  w_ready    out  1          weight column accept
  w_col      in   WIDTH*K    weight column, lane k at [k*WIDTH +: WIDTH]
  a_valid    in   1          A row valid
  a_ready    out  1          A row accept
  a_row      in   WIDTH*K    unskewed A row, lane k at [k*WIDTH +: WIDTH]
  weight_wen out  1          array weight write enable
  weight_din out  WIDTH*K    array weight data
  operand_a  out  WIDTH*K    skewed operand to array
  data_valid out  1          operand stream active
  col_valid  out  N          per-column result valid strobe
  busy       out  1          high when not IDLE
  done       out  1          one-cycle job completion pulse

Function
REQ-006 FSM states: IDLE, LOAD_W, STREAM, FLUSH, DONE.
REQ-007 IDLE: start=1 with load_w=1 -> LOAD_W; start=1 with load_w=0 and m_rows>0 -> STREAM; start=1 with m_rows=0 and load_w=0 -> DONE.
REQ-008 LOAD_W: w_ready=1; each w_valid&w_ready cycle drives weight_wen=1 and weight_din=w_col on the next cycle (registered); the first accepted column is array column N-1, the last is column 0.
REQ-009 LOAD_W exits after exactly N accepted columns, to STREAM if m_rows>0, otherwise to DONE; w_valid gaps stall without timeout.
REQ-010 STREAM: a_ready=1 until m_rows rows are accepted; each cycle with a_valid=0 inserts a zero bubble row that is not counted.
REQ-011 Skew: a row accepted at edge t SHALL drive lane k onto operand_a at cycle t+1+k; lanes with no live data SHALL be zero.
REQ-012 data_valid SHALL be high from the first operand cycle through cycle t_last+K, where t_last is the edge of the last accepted row, including bubble cycles.
REQ-013 A row-tag bit (1 = real row, 0 = bubble) SHALL travel with each row; col_valid[j] SHALL pulse at cycle t+K+2+j for each real row accepted at t, and SHALL never pulse for bubbles.
REQ-014 STREAM -> FLUSH on acceptance of the last row; FLUSH lasts K+N+2 cycles, so the last col_valid[N-1] precedes exit; FLUSH -> DONE.
REQ-015 DONE: done=1 for one cycle -> IDLE; busy=1 in every state except IDLE.
REQ-016 start while busy SHALL be ignored; m_rows>M_MAX SHALL be clamped to M_MAX.
REQ-017 The row counter SHALL saturate at m_rows and never wrap.

Reset
REQ-018 rst=1 at any clock edge SHALL force IDLE and clear every output, counter, skew register and tag pipeline to 0, including in mid-job; partial weights in the array are not restored.
REQ-019 After reset, w_ready=a_ready=0 until a new start is accepted.

Configuration
REQ-020 Macro WS_ARRAY_SEQ_PERF_EN defined: SHALL add outputs perf_busy_cyc[31:0] (cycles with busy=1) and perf_bubble_cyc[31:0] (STREAM cycles with a_valid=0); both saturate at all-ones, clear on rst, and hold across jobs.
REQ-021 Macro undefined: neither port nor counter SHALL exist; all other behaviour is identical.

Verification
REQ-022 K=N=4, start with load_w=1 and m_rows=4, 4 weight columns back-to-back -> weight_wen high for 4 consecutive cycles; the first weight_din equals the first w_col.
REQ-023 Rows accepted back-to-back at t0..t0+3 -> operand_a lane 2 carries row0 at t0+3; col_valid[3] pulses at t0+9..t0+12; done pulses once.
REQ-024 a_valid low for 2 cycles mid-stream -> 2 zero operand rows are inserted, no col_valid for them, and col_valid count per column is still 4.
REQ-025 start with m_rows=0 and load_w=0 -> done pulses 2 cycles after start, with no weight_wen and no data_valid.
REQ-026 rst asserted during FLUSH -> next cycle all outputs are 0 and busy=0; a new job then completes correctly.
REQ-027 With the macro defined, a 4-row job containing 2 bubbles -> perf_bubble_cyc=2, and perf_busy_cyc equals the counted busy cycles.
